skid_stage_regs: RTL and testbench
==================================

# skid_stage_regs

Parametrised, elastic successor to the fixed inter-stage pipeline registers. It carries one instruction's PC, data payload and control bundle between two pipeline stages using a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. Flush clears control bits to produce bubbles, and saturating stall and bubble counters support performance analysis. It is used first at the ID/EX boundary and then at EX/MEM and MEM/WB.

## Interface
Parameters:
- `DATA_WIDTH`, 64: PC width.
- `PAYLOAD_WIDTH`, 256: packed data fields (operands, immediate, register ids); never cleared by flush.
- `CTRL_WIDTH`, 20: packed control bundle (ex/mem/wb controls); zero means NOP.
- `CNT_WIDTH`, 32: width of the performance counters.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset; synchronous, active-low.
- `flush`, in, 1: kill all held entries this cycle.
- `hold`, in, 1: external stall; output entry is frozen.
- `in_valid`, in, 1: upstream presents an entry.
- `in_ready`, out, 1: stage can accept; registered.
- `in_pc`, in, `DATA_WIDTH`: upstream PC.
- `in_payload`, in, `PAYLOAD_WIDTH`: upstream data fields.
- `in_ctrl`, in, `CTRL_WIDTH`: upstream control bundle.
- `out_valid`, out, 1: output entry valid.
- `out_ready`, in, 1: downstream accepts.
- `out_pc`, out, `DATA_WIDTH`: output PC.
- `out_payload`, out, `PAYLOAD_WIDTH`: output data fields.
- `out_ctrl`, out, `CTRL_WIDTH`: output control bundle.
- `stall_cnt`, out, `CNT_WIDTH`: saturating count of stall cycles.
- `bubble_cnt`, out, `CNT_WIDTH`: saturating count of bubble cycles.

## Operation
- Transfer rules:
  - Accept when `in_valid && in_ready`.
  - Emit when `out_valid && drain`, where `drain = out_ready && !hold`.
- Entries:
  - MAIN drives all `out_*` signals.
  - SKID holds the overflow entry.
- States: EMPTY (no valid entry), ONE (MAIN valid), FULL (MAIN and SKID valid).
- Transitions:
  - EMPTY: accept → ONE.
  - ONE, accept with no drain → FULL; the entry goes to SKID.
  - ONE, accept with drain → ONE; the entry replaces MAIN.
  - ONE, drain with no accept → EMPTY.
  - FULL, drain → ONE; SKID moves to MAIN.
- In FULL, `in_ready` is 0, so no accept is possible.
- `in_ready = (state != FULL)`, registered from the next state.
- `out_valid = (state != EMPTY)`.
- `out_ctrl` is forced to 0 whenever `out_valid = 0`, so a bubble is always a NOP.
- `out_pc` and `out_payload` keep their last value when invalid.
- `flush`:
  - Next state is EMPTY.
  - Control fields of both entries are zeroed.
  - A same-cycle input is dropped, even when `in_valid && in_ready`.
  - PC and payload registers are not cleared.
  - `flush` overrides `hold`.
- `hold`: identical to `out_ready = 0`; input can still fill SKID.
- Counters, both saturating at all-ones and never wrapping:
  - `stall_cnt` increments on cycles with `out_valid && !drain`.
  - `bubble_cnt` increments on cycles with `!out_valid`.
  - Neither counter increments on a flush cycle.
- `reset_n = 0`:
  - State EMPTY, `in_ready = 1`, `out_valid = 0`.
  - `out_pc`, `out_payload`, `out_ctrl` = 0.
  - Both counters = 0.
  - Reset overrides flush and any in-flight handshake.

## Timing
- Latency: an entry accepted at edge N appears on `out_*` after edge N, with `out_valid = 1`, in cycle N+1.
- Throughput: one entry per cycle sustained when `drain = 1` every cycle.
- `in_ready` drops the cycle after the second un-drained accept. It rises the cycle after the first drain out of FULL.
- No combinational path from `out_ready`/`hold` to `in_ready`.
- Entry order is strictly FIFO; no entry is duplicated or lost except by flush or reset.

## Structure
- Package `pipe_pkg`: `stage_state_t` enum (EMPTY, ONE, FULL) and constant `CTRL_NOP = '0`.
- Sub-module `pipe_entry`: one register slot with valid bit, ctrl, PC and payload, with load and clear-ctrl inputs. It is instantiated twice, as MAIN and SKID.
- State machine and counters live in the top level.

## Test plan
- Stream of 8 entries, PCs 0x100, 0x104, … with `out_ready = 1`: one output per cycle, 1-cycle latency, `stall_cnt = 0`.
- `out_ready = 0` for 3 cycles while 2 entries arrive:
  - `in_ready` falls after the second accept.
  - `stall_cnt` rises by 2.
  - After release, the order is PC 0x200 then 0x204.
- In FULL, assert `flush` together with `in_valid`:
  - Next cycle: `out_valid = 0`, `out_ctrl = 0`, `in_ready = 1`.
  - The input is dropped; the flush cycle adds nothing to the counters.
- `hold = 1` with `out_ready = 1` for 2 cycles: behaves exactly like `out_ready = 0`, and `out_pc` is stable.
- Preload both counters to all-ones minus 1 by forced stall/bubble: each saturates at all-ones and never wraps to 0.
- Drop `reset_n` for 1 cycle while in FULL: all outputs and counters are 0 and `in_ready = 1` on the next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for elastic pipeline stage registers
package pipe_pkg;

    // Occupancy of a two-entry stage: nothing, MAIN only, MAIN plus SKID.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    // Widest control bundle any stage instance may carry; CTRL_NOP is
    // sliced down to the instance's CTRL_WIDTH.
    localparam int unsigned MAX_CTRL_WIDTH = 256;

    // An all-zero control bundle is a NOP.
    localparam logic [MAX_CTRL_WIDTH-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one stage entry slot: valid, ctrl, pc and payload registers
//
// Ports:
//   clk, reset_n     clock, synchronous active-low reset (clears everything)
//   load_i           capture valid_i/ctrl_i/pc_i/payload_i
//   unload_i         drop the valid bit, keep the fields
//   clear_ctrl_i     kill: valid and ctrl go to zero, pc/payload kept
//   valid_i..        data to capture on load_i
//   valid_o..        registered slot contents
module pipe_entry
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int PAYLOAD_WIDTH = 256,
    parameter int CTRL_WIDTH    = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_i,
    input  logic                     unload_i,
    input  logic                     clear_ctrl_i,
    input  logic                     valid_i,
    input  logic [CTRL_WIDTH-1:0]    ctrl_i,
    input  logic [DATA_WIDTH-1:0]    pc_i,
    input  logic [PAYLOAD_WIDTH-1:0] payload_i,
    output logic                     valid_o,
    output logic [CTRL_WIDTH-1:0]    ctrl_o,
    output logic [DATA_WIDTH-1:0]    pc_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o
);

    logic                     valid_q,   valid_d;
    logic [CTRL_WIDTH-1:0]    ctrl_q,    ctrl_d;
    logic [DATA_WIDTH-1:0]    pc_q,      pc_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;

    // Kill beats load: a flushed cycle must never capture the incoming entry.
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        pc_d      = pc_q;
        payload_d = payload_q;
        if (clear_ctrl_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP[CTRL_WIDTH-1:0];
        end else if (load_i) begin
            valid_d   = valid_i;
            ctrl_d    = ctrl_i;
            pc_d      = pc_i;
            payload_d = payload_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP[CTRL_WIDTH-1:0];
            pc_q      <= '0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            pc_q      <= pc_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign ctrl_o    = ctrl_q;
    assign pc_o      = pc_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/skid_stage_regs.sv
// rtl/skid_stage_regs.sv - elastic two-entry inter-stage register with flush and perf counters
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   flush                            kill held entries and any same-cycle input
//   hold                             external stall, acts as out_ready = 0
//   in_valid/in_ready                upstream handshake (in_ready registered)
//   in_pc/in_payload/in_ctrl         upstream entry
//   out_valid/out_ready              downstream handshake
//   out_pc/out_payload/out_ctrl      MAIN entry; ctrl reads NOP while invalid
//   stall_cnt/bubble_cnt             saturating performance counters
module skid_stage_regs
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int PAYLOAD_WIDTH = 256,
    parameter int CTRL_WIDTH    = 20,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     hold,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    input  logic [CTRL_WIDTH-1:0]    in_ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [CTRL_WIDTH-1:0]    out_ctrl,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     bubble_cnt
);

    stage_state_t state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] bubble_cnt_q, bubble_cnt_d;

    logic accept;
    logic drain;
    logic main_load, main_unload, main_from_skid;
    logic skid_load, skid_unload;

    logic                     main_valid_in;
    logic [CTRL_WIDTH-1:0]    main_ctrl_in;
    logic [DATA_WIDTH-1:0]    main_pc_in;
    logic [PAYLOAD_WIDTH-1:0] main_payload_in;

    logic                     main_valid,   skid_valid;
    logic [CTRL_WIDTH-1:0]    main_ctrl,    skid_ctrl;
    logic [DATA_WIDTH-1:0]    main_pc,      skid_pc;
    logic [PAYLOAD_WIDTH-1:0] main_payload, skid_payload;

    // in_ready_q is 0 only in FULL, so accept never happens there.
    assign accept = in_valid && in_ready_q;
    assign drain  = out_ready && !hold;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_unload    = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_unload    = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        state_d   = FULL;
                        skid_load = 1'b1;
                    end else if (accept) begin
                        main_load = 1'b1;
                    end else if (drain) begin
                        state_d     = EMPTY;
                        main_unload = 1'b1;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_unload    = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Registered from the next state so in_ready has no path from out_ready/hold.
    assign in_ready_d = (state_d != FULL);

    assign main_valid_in   = main_from_skid ? skid_valid   : 1'b1;
    assign main_ctrl_in    = main_from_skid ? skid_ctrl    : in_ctrl;
    assign main_pc_in      = main_from_skid ? skid_pc      : in_pc;
    assign main_payload_in = main_from_skid ? skid_payload : in_payload;

    // Flush cycles are excluded from both counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!flush) begin
            if ((state_q != EMPTY) && !drain && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
            end
            if ((state_q == EMPTY) && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    pipe_entry #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
        .CTRL_WIDTH   (CTRL_WIDTH)
    ) u_main (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (main_load),
        .unload_i    (main_unload),
        .clear_ctrl_i(flush),
        .valid_i     (main_valid_in),
        .ctrl_i      (main_ctrl_in),
        .pc_i        (main_pc_in),
        .payload_i   (main_payload_in),
        .valid_o     (main_valid),
        .ctrl_o      (main_ctrl),
        .pc_o        (main_pc),
        .payload_o   (main_payload)
    );

    pipe_entry #(
        .DATA_WIDTH   (DATA_WIDTH),
        .PAYLOAD_WIDTH(PAYLOAD_WIDTH),
        .CTRL_WIDTH   (CTRL_WIDTH)
    ) u_skid (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (skid_load),
        .unload_i    (skid_unload),
        .clear_ctrl_i(flush),
        .valid_i     (1'b1),
        .ctrl_i      (in_ctrl),
        .pc_i        (in_pc),
        .payload_i   (in_payload),
        .valid_o     (skid_valid),
        .ctrl_o      (skid_ctrl),
        .pc_o        (skid_pc),
        .payload_o   (skid_payload)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != EMPTY);
    assign out_pc      = main_pc;
    assign out_payload = main_payload;
    // MAIN's valid bit tracks state != EMPTY; masking keeps bubbles as NOPs.
    assign out_ctrl    = main_valid ? main_ctrl : CTRL_NOP[CTRL_WIDTH-1:0];
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_skid_stage_regs.sv
// tb/tb_skid_stage_regs.sv - scoreboard bench for skid_stage_regs
module tb_skid_stage_regs;

    localparam int DW   = 32;
    localparam int PW   = 16;
    localparam int CW   = 8;
    localparam int NW   = 6;
    localparam int CMAX = (1 << NW) - 1;

    typedef struct {
        logic [DW-1:0] pc;
        logic [PW-1:0] payload;
        logic [CW-1:0] ctrl;
    } entry_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          hold;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pc;
    logic [PW-1:0] in_payload;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pc;
    logic [PW-1:0] out_payload;
    logic [CW-1:0] out_ctrl;
    logic [NW-1:0] stall_cnt;
    logic [NW-1:0] bubble_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_on = 1'b0;

    entry_t exp_q[$];
    int     exp_stall = 0;
    int     exp_bubble = 0;
    int     b_before;

    skid_stage_regs #(
        .DATA_WIDTH   (DW),
        .PAYLOAD_WIDTH(PW),
        .CTRL_WIDTH   (CW),
        .CNT_WIDTH    (NW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .hold       (hold),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_payload (in_payload),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_payload(out_payload),
        .out_ctrl   (out_ctrl),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] pc);
        in_valid   = v;
        in_pc      = pc;
        in_payload = PW'($urandom_range(0, 16'hffff));
        in_ctrl    = CW'($urandom_range(1, 255));
    endtask

    // Check current outputs against the model, then advance the model by
    // the edge that follows, using the inputs that edge will see.
    always @(negedge clk) begin
        bit drn;
        bit acc;
        if (chk_on) begin
            check_eq("out_valid", out_valid, exp_q.size() != 0);
            check_eq("in_ready", in_ready, exp_q.size() < 2);
            check_eq("stall_cnt", stall_cnt, exp_stall);
            check_eq("bubble_cnt", bubble_cnt, exp_bubble);
            if (exp_q.size() == 0) begin
                check_eq("bubble_ctrl", out_ctrl, 0);
            end else begin
                check_eq("sb_pc", out_pc, exp_q[0].pc);
                check_eq("sb_payload", out_payload, exp_q[0].payload);
                check_eq("sb_ctrl", out_ctrl, exp_q[0].ctrl);
            end
        end
        if (!reset_n) begin
            exp_q.delete();
            exp_stall  = 0;
            exp_bubble = 0;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            drn = out_ready && !hold;
            acc = in_valid && (exp_q.size() < 2);
            if (exp_q.size() != 0 && !drn && exp_stall < CMAX) exp_stall++;
            if (exp_q.size() == 0 && exp_bubble < CMAX) exp_bubble++;
            if (exp_q.size() != 0 && drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back('{pc: in_pc, payload: in_payload, ctrl: in_ctrl});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        hold      = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, '0);
        step();
        chk_on = 1'b1;
        step();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_pc", out_pc, 0);
        check_eq("rst_out_ctrl", out_ctrl, 0);
        check_eq("rst_stall", stall_cnt, 0);
        check_eq("rst_bubble", bubble_cnt, 0);
        reset_n = 1'b1;
        step();

        // Streaming at full rate, one-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, DW'(32'h100 + 4 * i));
            step();
            check_eq("stream_pc", out_pc, 32'h100 + 4 * i);
            check_eq("stream_valid", out_valid, 1);
            check_eq("stream_in_ready", in_ready, 1);
        end
        drive(1'b0, '0);
        step();
        check_eq("stream_drained", out_valid, 0);
        check_eq("stream_stall", stall_cnt, 0);

        // Back-pressure fills SKID; order preserved on release.
        out_ready = 1'b0;
        drive(1'b1, 32'h200);
        step();
        check_eq("bp_in_ready1", in_ready, 1);
        drive(1'b1, 32'h204);
        step();
        check_eq("bp_in_ready_low", in_ready, 0);
        drive(1'b0, '0);
        step();
        check_eq("bp_stall", stall_cnt, 2);
        out_ready = 1'b1;
        check_eq("bp_first", out_pc, 32'h200);
        step();
        check_eq("bp_second", out_pc, 32'h204);
        check_eq("bp_in_ready_up", in_ready, 1);
        step();
        check_eq("bp_empty", out_valid, 0);

        // Flush while FULL with a same-cycle input.
        out_ready = 1'b0;
        drive(1'b1, 32'h300);
        step();
        drive(1'b1, 32'h304);
        step();
        check_eq("fl_full", in_ready, 0);
        drive(1'b1, 32'h308);
        flush = 1'b1;
        b_before = exp_bubble;
        step();
        flush = 1'b0;
        drive(1'b0, '0);
        check_eq("fl_valid", out_valid, 0);
        check_eq("fl_ctrl", out_ctrl, 0);
        check_eq("fl_in_ready", in_ready, 1);
        check_eq("fl_stall", stall_cnt, 3);
        check_eq("fl_bubble", bubble_cnt, b_before);
        step();
        check_eq("fl_dropped", out_valid, 0);

        // hold with out_ready high behaves as back-pressure.
        out_ready = 1'b1;
        hold      = 1'b1;
        drive(1'b1, 32'h400);
        step();
        drive(1'b1, 32'h404);
        step();
        check_eq("hold_in_ready", in_ready, 0);
        check_eq("hold_pc_a", out_pc, 32'h400);
        drive(1'b0, '0);
        step();
        check_eq("hold_pc_b", out_pc, 32'h400);
        check_eq("hold_stall", stall_cnt, 5);
        hold = 1'b0;
        step();
        check_eq("hold_rel_pc", out_pc, 32'h404);
        step();
        check_eq("hold_empty", out_valid, 0);

        // Bubble counter saturation.
        for (int i = 0; i < 100 && exp_bubble != CMAX - 1; i++) step();
        check_eq("bub_pre", bubble_cnt, CMAX - 1);
        step();
        check_eq("bub_sat", bubble_cnt, CMAX);
        step();
        check_eq("bub_nowrap", bubble_cnt, CMAX);

        // Stall counter saturation.
        out_ready = 1'b0;
        drive(1'b1, 32'h500);
        step();
        drive(1'b0, '0);
        for (int i = 0; i < 100 && exp_stall != CMAX - 1; i++) step();
        check_eq("stall_pre", stall_cnt, CMAX - 1);
        step();
        check_eq("stall_sat", stall_cnt, CMAX);
        step();
        check_eq("stall_nowrap", stall_cnt, CMAX);

        // Reset while FULL, with flush and a handshake in flight.
        drive(1'b1, 32'h504);
        step();
        check_eq("rf_full", in_ready, 0);
        reset_n   = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h508);
        step();
        check_eq("rf_out_valid", out_valid, 0);
        check_eq("rf_in_ready", in_ready, 1);
        check_eq("rf_out_pc", out_pc, 0);
        check_eq("rf_out_payload", out_payload, 0);
        check_eq("rf_out_ctrl", out_ctrl, 0);
        check_eq("rf_stall", stall_cnt, 0);
        check_eq("rf_bubble", bubble_cnt, 0);
        reset_n = 1'b1;
        flush   = 1'b0;
        drive(1'b0, '0);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
